// File: rtl/pipe_ctrl.sv
// Stall/flush/exception sequencer for the five-stage pipeline: drives every
// pipeline register's write-enable, flush and Req, and times the multiply/divide unit.
module pipe_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_hz_stall,
  input  logic        D_uses_md,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        exc_req,
  input  logic        M_eret,
  output logic        pc_wren,
  output logic        fd_wren,
  output logic        de_wren,
  output logic        em_wren,
  output logic        mw_wren,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        Req,
  output logic        stall,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_REQ,
    MODE_ERET,
    MODE_STALL,
    MODE_NORMAL
  } mode_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             start_accepted;
  logic             stall_req;
  mode_e            mode;

  // Req and eret both squash an E-stage MDU start; reset blocks it too.
  assign start_accepted = reset & E_md_start & ~exc_req & ~M_eret;
  assign md_busy        = reset & (start_accepted | (md_cnt_q != '0));
  assign stall_req      = D_hz_stall | (D_uses_md & md_busy);
  assign Req            = exc_req;
  assign stall_cnt      = stall_cnt_q;

  always_comb begin
    if (!reset)           mode = MODE_RESET;
    else if (exc_req)     mode = MODE_REQ;
    else if (M_eret)      mode = MODE_ERET;
    else if (stall_req)   mode = MODE_STALL;
    else                  mode = MODE_NORMAL;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pc_wren  = 1'b1;
    fd_wren  = 1'b1;
    de_wren  = 1'b1;
    em_wren  = 1'b1;
    mw_wren  = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    em_flush = 1'b0;
    stall    = 1'b0;
    unique case (mode)
      MODE_ERET: begin
        fd_flush = 1'b1;
        de_flush = 1'b1;
        em_flush = 1'b1;
      end
      MODE_STALL: begin
        pc_wren  = 1'b0;
        fd_wren  = 1'b0;
        de_flush = 1'b1;
        stall    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (mode == MODE_REQ)        md_cnt_d = '0;
    else if (start_accepted)     md_cnt_d = E_md_div ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt_q != '0)     md_cnt_d = md_cnt_q - 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed control words per cycle,
// MDU busy windows, priority cases and stall-counter saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_hz_stall, D_uses_md, E_md_start, E_md_div, exc_req, M_eret;
  logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
  logic        fd_flush, de_flush, em_flush, Req, stall, md_busy;
  logic [15:0] stall_cnt;
  logic [9:0]  ctl;

  int n_cmp = 0;
  int n_bad = 0;

  // {pc,fd,de,em,mw wren, fd,de,em flush, Req, stall}
  localparam logic [9:0] C_NORM  = 10'b11111_000_0_0;
  localparam logic [9:0] C_STALL = 10'b00111_010_0_1;
  localparam logic [9:0] C_ERET  = 10'b11111_111_0_0;
  localparam logic [9:0] C_REQ   = 10'b11111_000_1_0;

  pipe_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_hz_stall (D_hz_stall),
    .D_uses_md  (D_uses_md),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .exc_req    (exc_req),
    .M_eret     (M_eret),
    .pc_wren    (pc_wren),
    .fd_wren    (fd_wren),
    .de_wren    (de_wren),
    .em_wren    (em_wren),
    .mw_wren    (mw_wren),
    .fd_flush   (fd_flush),
    .de_flush   (de_flush),
    .em_flush   (em_flush),
    .Req        (Req),
    .stall      (stall),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  assign ctl = {pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                fd_flush, de_flush, em_flush, Req, stall};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic hz, input logic umd, input logic st,
                       input logic dv, input logic exc, input logic eret);
    D_hz_stall = hz;
    D_uses_md  = umd;
    E_md_start = st;
    E_md_div   = dv;
    exc_req    = exc;
    M_eret     = eret;
  endtask

  // Inputs are already applied; settle, compare, then advance one clock.
  task automatic cyc(input string tag, input logic [9:0] exp_ctl, input logic exp_busy);
    #1;
    check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
    check({tag, "_busy"}, 32'(md_busy), 32'(exp_busy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1, 1, 1, 0, 0, 0);
    #2;
    cyc("rst_pulse", C_NORM, 0);
    drive(1, 1, 1, 1, 0, 1);
    cyc("rst_pulse2", C_NORM, 0);
    drive(0, 0, 0, 0, 1, 0);
    cyc("rst_req", C_REQ, 0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cyc("idle", C_NORM, 0);

    // Three hazard stalls.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hz_cnt%0d", i), 32'(stall_cnt), 32'(i));
      cyc($sformatf("hz%0d", i), C_STALL, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    check("hz_cnt", 32'(stall_cnt), 32'd3);
    cyc("hz_done", C_NORM, 0);

    // Mult start at T with dependent instruction in D: stalls T..T+5.
    drive(0, 1, 1, 0, 0, 0);
    cyc("mult_T", C_STALL, 1);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc($sformatf("mult_T%0d", i), C_STALL, 1);
    cyc("mult_T6", C_NORM, 0);
    check("mult_cnt", 32'(stall_cnt), 32'd9);

    // Div start, exception three cycles later aborts the timer.
    drive(0, 0, 1, 1, 0, 0);
    cyc("div_T", C_NORM, 1);
    drive(0, 0, 0, 0, 0, 0);
    cyc("div_T1", C_NORM, 1);
    cyc("div_T2", C_NORM, 1);
    drive(0, 1, 0, 0, 1, 0);
    cyc("div_req", C_REQ, 1);
    drive(0, 1, 0, 0, 0, 0);
    cyc("div_abort", C_NORM, 0);
    check("div_cnt", 32'(stall_cnt), 32'd9);

    // Eret squashes a concurrent MDU start and overrides a hazard stall.
    drive(1, 1, 1, 0, 0, 1);
    cyc("eret", C_ERET, 0);
    drive(0, 1, 0, 0, 0, 0);
    cyc("eret_next", C_NORM, 0);
    check("eret_cnt", 32'(stall_cnt), 32'd9);

    // Req beats eret and stall together.
    drive(1, 0, 0, 0, 1, 1);
    cyc("prio", C_REQ, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("prio_cnt", 32'(stall_cnt), 32'd9);

    // Full div busy window with dependent D instruction: T..T+10.
    drive(0, 1, 1, 1, 0, 0);
    cyc("divw_T", C_STALL, 1);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc($sformatf("divw_T%0d", i), C_STALL, 1);
    cyc("divw_T11", C_NORM, 0);
    check("divw_cnt", 32'(stall_cnt), 32'd20);

    // Saturation.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    cyc("sat_stall", C_STALL, 0);
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    drive(0, 0, 0, 0, 0, 0);
    cyc("sat_end", C_NORM, 0);
    check("sat_final", 32'(stall_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
